// File: rtl/l2_bank_arb_pkg.sv
// L2 bank arbiter shared types and constants.
// Optional zero-fill FSM enabled by L2_BANK_ARB_INIT_EN.
package l2_bank_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    INIT = 1'b1
  } state_e;

  localparam logic MEM_CSN_IDLE = 1'b1;
  localparam logic MEM_WEN_IDLE = 1'b1;

endpackage

// File: rtl/l2_rr_arbiter.sv
// Round-robin selector: first requester after ptr wins.
// Purely combinational; caller owns the pointer register.
module l2_rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic found;

  // scan ptr+1, ptr+2, ... modulo N; first hit wins
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int i = 1; i <= N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (!found && req[j] &&
            j == (int'(ptr) + i) % N) begin
          gnt[j] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/l2_bank_arbiter.sv
// Shares one L2 bank between NB_REQ ports, one access/cycle.
// Define L2_BANK_ARB_INIT_EN to add the zero-fill INIT state.
module l2_bank_arbiter
  import l2_bank_arb_pkg::*;
#(
  parameter int NB_REQ     = 2,
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic init_ni,
  input  logic [NB_REQ-1:0] req_i,
  input  logic [NB_REQ-1:0][ADDR_WIDTH-1:0] add_i,
  input  logic [NB_REQ-1:0] wen_i,
  input  logic [NB_REQ-1:0][DATA_WIDTH/8-1:0] be_i,
  input  logic [NB_REQ-1:0][DATA_WIDTH-1:0] wdata_i,
  output logic [NB_REQ-1:0] gnt_o,
  output logic [NB_REQ-1:0] rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic mem_csn_o,
  output logic mem_wen_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [ADDR_WIDTH-1:0] mem_add_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic init_done_o
);

  localparam int PW = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;

  logic [PW-1:0]         ptr_q, ptr_d;
  logic [NB_REQ-1:0]     rr_gnt, rvalid_q;
  logic                  serve, filling;
  logic [ADDR_WIDTH-1:0] fill_add;

`ifdef L2_BANK_ARB_INIT_EN
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  // fsm state and fill counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // fill walks every word once, then returns to IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (!init_ni) state_d = INIT;
      INIT: begin
        if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign serve       = rst_ni && (state_q == IDLE);
  assign filling     = rst_ni && (state_q == INIT);
  assign fill_add    = cnt_q;
  assign init_done_o = (state_q == IDLE);
`else
  logic unused_init;
  assign unused_init = init_ni;
  assign serve       = rst_ni;
  assign filling     = 1'b0;
  assign fill_add    = '0;
  assign init_done_o = 1'b1;
`endif

  l2_rr_arbiter #(
    .N  (NB_REQ),
    .PW (PW)
  ) u_rr (
    .req (req_i),
    .ptr (ptr_q),
    .gnt (rr_gnt)
  );

  assign gnt_o = serve ? rr_gnt : '0;

  // pointer follows the granted port
  always_comb begin
    ptr_d = ptr_q;
    for (int k = 0; k < NB_REQ; k++) begin
      if (gnt_o[k]) ptr_d = PW'(k);
    end
  end

  // bank port: fill, granted port, or idle
  always_comb begin
    mem_csn_o   = MEM_CSN_IDLE;
    mem_wen_o   = MEM_WEN_IDLE;
    mem_be_o    = '0;
    mem_add_o   = '0;
    mem_wdata_o = '0;
    if (filling) begin
      mem_csn_o = 1'b0;
      mem_wen_o = 1'b0;
      mem_be_o  = '1;
      mem_add_o = fill_add;
    end else begin
      for (int k = 0; k < NB_REQ; k++) begin
        if (gnt_o[k]) begin
          mem_csn_o   = 1'b0;
          mem_wen_o   = wen_i[k];
          mem_be_o    = be_i[k];
          mem_add_o   = add_i[k];
          mem_wdata_o = wdata_i[k];
        end
      end
    end
  end

  // pointer and response strobe registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q    <= PW'(NB_REQ - 1);
      rvalid_q <= '0;
    end else begin
      ptr_q    <= ptr_d;
      rvalid_q <= gnt_o;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = (|rvalid_q) ? mem_rdata_i : '0;

endmodule
